prng_uart_tx: RTL and testbench
===============================

Name: prng_uart_tx

Overview:
- Serial transmitter that carries PRNG output bytes off-chip as 8-bit UART frames: start, 8 data bits LSB first, optional parity, 1 stop.
- Sits between the PRNG core's byte stream and a dedicated output pin of tt_um_top.
- Input side: valid/ready byte handshake with a 1-deep holding register, so back-to-back frames leave no idle gap on the line.

Parameters:
- CLK_HZ, 10_000_000, system clock frequency in Hz.
- BAUD, 115_200, line rate in bit/s. Bit period DIV = CLK_HZ/BAUD, truncated; DIV must be >= 2.
- PARITY, 0, parity mode: 0 = none, 1 = even, 2 = odd.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- in_data  in  8  byte to send.
- in_valid  in  1  in_data is valid this cycle.
- in_ready  out  1  holding register is empty; a byte is accepted when in_valid && in_ready.
- tx  out  1  serial line, idles high.
- busy  out  1  a frame is being shifted, or a byte is waiting.
- frames_sent  out  16  count of completed frames; wraps modulo 2^16.

Behaviour:
- Reset (rst high at a clk edge) values, all taking effect at that edge:
  - tx=1, busy=0, in_ready=1, frames_sent=0.
  - FSM goes to IDLE.
  - Holding register is cleared and the baud counter is zeroed.
- States and transitions:
  - IDLE: tx=1. If the holding register is full, load the shifter, clear the holding register and go to START.
  - START: tx=0 for DIV cycles, then go to DATA.
  - DATA: tx = shift[0] for DIV cycles per bit; shift right after each bit. After bit 7, go to PARITY (PARITY!=0) or STOP.
  - PARITY: tx = XOR of the 8 data bits (even) or its inverse (odd), for DIV cycles.
  - STOP: tx=1 for DIV cycles. On the last stop cycle:
    - frames_sent increments.
    - If the holding register is full, load the shifter and go directly to START, so there is no idle cycle between frames.
    - Otherwise go to IDLE.
- Latency: a byte accepted at edge N while the FSM is IDLE and the buffer is empty is loaded at edge N+1, and tx falls at edge N+1. Frame start is therefore 1 cycle after acceptance.
- Handshake:
  - in_ready = !hold_full (registered state, no combinational path from in_valid).
  - in_valid while in_ready=0 is ignored. The sender must hold its data until the transfer is accepted.
- Simultaneous events:
  - The holding register is loaded and emptied in the same cycle (accept while the shifter takes the old byte): the new byte is stored and hold_full stays 1.
  - A byte accepted on the same edge as the last STOP cycle while the buffer was empty is loaded on the next edge. This gives 1 idle cycle, which is permitted only in this case.
- Baud counter: counts 0..DIV-1 and wraps; the bit boundary is at DIV-1. The counter is reset to 0 on every load into START.
- busy = (state != IDLE) || hold_full.
- Reset mid-frame: tx goes to 1 at the reset edge and any buffered byte is discarded. The truncated frame is not counted.
- frames_sent: 0xFFFF + 1 wraps to 0x0000.

Decomposition:
- Shared package prng_io_pkg holds:
  - the state enum (IDLE, START, DATA, PARITY, STOP);
  - PARITY_NONE, PARITY_EVEN, PARITY_ODD constants;
  - a DIV-calculation function with an elaboration-time assertion that DIV >= 2.
- One sub-module, uart_baud_tick: parameterised DIV counter with a restart input and a 1-cycle tick output. Reused later by the matching receiver.

Test Plan:
Bench settings: CLK_HZ=10_000_000, BAUD=1_000_000, giving DIV=10.
1. Reset, PARITY=0. Send 0xA5 with in_valid for 1 cycle.
   - tx=0 for cycles 1..10 after acceptance.
   - Then data bits 1,0,1,0,0,1,0,1, each 10 cycles wide.
   - Then tx=1 for 10 cycles.
   - frames_sent=1, busy=0 after cycle 100.
2. Back-to-back: send 0x00 then 0xFF on consecutive accepts.
   - in_ready drops after the 2nd accept and rises at the 0x00 stop end.
   - The 0xFF start bit begins immediately after that stop end: total 200 cycles of frames, no idle gap.
3. Backpressure: hold in_valid with 0x11, 0x22, 0x33 while in_ready toggles.
   - Exactly three frames are sent, in order.
   - No byte is duplicated or dropped; frames_sent=3.
4. PARITY=1, send 0x07 → parity bit 1. PARITY=2, send 0x07 → parity bit 0. Frame is 110 cycles in both cases.
5. Assert rst at cycle 45 of a 0xFF frame, with 0x3C buffered.
   - tx=1 at that edge; in_ready=1, busy=0, frames_sent unchanged at 0.
   - A subsequent 0x3C send frames normally.
6. Preload frames_sent to 0xFFFF via 65535 frames (or a force), send one more byte → frames_sent reads 0x0000.

Source files
------------

// File: rtl/prng_io_pkg.sv
// Shared definitions for the PRNG serial I/O blocks (transmitter and future receiver).
package prng_io_pkg;

    // UART frame sequencing states
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_state_e;

    localparam int unsigned PARITY_NONE = 0;
    localparam int unsigned PARITY_EVEN = 1;
    localparam int unsigned PARITY_ODD  = 2;

    localparam int unsigned DATA_BITS   = 8;

    // Bit period in clock cycles, truncated; callers must ensure the result is >= 2
    function automatic int unsigned calc_div(input int unsigned clk_hz, input int unsigned baud);
        return clk_hz / baud;
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period counter: counts 0..DIV-1 and raises tick_o for the cycle in which the count is DIV-1.
module uart_baud_tick #(
    parameter int unsigned DIV = 87
) (
    input  logic clk,
    input  logic rst,
    input  logic restart_i,
    output logic tick_o
);
    import prng_io_pkg::*;

    localparam int unsigned CNT_W = (DIV > 2) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);

    // A one-cycle bit period would leave no room for the load/transition cycle
    if (DIV < 2) begin : g_div_check
        $error("uart_baud_tick: DIV must be >= 2");
    end

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             tick_q;

    // Next count: wrap at the bit boundary, zero on restart
    always_comb begin
        cnt_d = cnt_q + CNT_W'(1);
        if (restart_i || (cnt_q == CNT_LAST)) begin
            cnt_d = '0;
        end
    end

    // Counter and registered tick, aligned so tick_q is high while cnt_q == DIV-1
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= (cnt_d == CNT_LAST);
        end
    end

    assign tick_o = tick_q;

endmodule

// File: rtl/prng_uart_tx.sv
// UART transmitter for PRNG bytes: 8N1 or 8E1/8O1 frames, with a one-byte holding register.
module prng_uart_tx #(
    parameter int unsigned CLK_HZ = 10_000_000,
    parameter int unsigned BAUD   = 115_200,
    parameter int unsigned PARITY = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic        tx,
    output logic        busy,
    output logic [15:0] frames_sent
);
    import prng_io_pkg::*;

    localparam int unsigned DIV = calc_div(CLK_HZ, BAUD);

    uart_state_e state_q;
    logic        tx_q;
    logic [7:0]  hold_q;
    logic        hold_full_q;
    logic [7:0]  shift_q;
    logic        par_q;
    logic [2:0]  bit_q;
    logic [15:0] frames_q;

    logic        tick;
    logic        load_c;
    logic        accept_c;
    logic        stop_done_c;
    logic        par_bit_c;

    // Restarted on every load so the start bit is always a full DIV cycles wide
    uart_baud_tick #(
        .DIV (DIV)
    ) u_baud (
        .clk       (clk),
        .rst       (rst),
        .restart_i (load_c),
        .tick_o    (tick)
    );

    // Handshake, shifter-load and frame-completion decodes
    always_comb begin
        accept_c    = in_valid && !hold_full_q;
        stop_done_c = (state_q == ST_STOP) && tick;
        load_c      = hold_full_q && ((state_q == ST_IDLE) || stop_done_c);
        par_bit_c   = (PARITY == PARITY_ODD) ? ~par_q : par_q;
    end

    // Holding register, frame counter and frame sequencing
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            tx_q        <= 1'b1;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            shift_q     <= '0;
            par_q       <= 1'b0;
            bit_q       <= '0;
            frames_q    <= '0;
        end else begin
            frames_q <= frames_q + 16'(stop_done_c);

            if (accept_c) begin
                hold_q      <= in_data;
                hold_full_q <= 1'b1;
            end else if (load_c) begin
                hold_full_q <= 1'b0;
            end

            case (state_q)
                ST_IDLE: begin
                    tx_q <= 1'b1;
                    if (load_c) begin
                        shift_q <= hold_q;
                        par_q   <= ^hold_q;
                        bit_q   <= '0;
                        tx_q    <= 1'b0;
                        state_q <= ST_START;
                    end
                end
                ST_START: begin
                    if (tick) begin
                        tx_q    <= shift_q[0];
                        state_q <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (tick) begin
                        shift_q <= shift_q >> 1;
                        if (bit_q == 3'(DATA_BITS - 1)) begin
                            if (PARITY != PARITY_NONE) begin
                                tx_q    <= par_bit_c;
                                state_q <= ST_PARITY;
                            end else begin
                                tx_q    <= 1'b1;
                                state_q <= ST_STOP;
                            end
                        end else begin
                            bit_q <= bit_q + 3'd1;
                            tx_q  <= shift_q[1];
                        end
                    end
                end
                ST_PARITY: begin
                    if (tick) begin
                        tx_q    <= 1'b1;
                        state_q <= ST_STOP;
                    end
                end
                ST_STOP: begin
                    if (tick) begin
                        // Chain straight into the next start bit when a byte is waiting
                        if (hold_full_q) begin
                            shift_q <= hold_q;
                            par_q   <= ^hold_q;
                            bit_q   <= '0;
                            tx_q    <= 1'b0;
                            state_q <= ST_START;
                        end else begin
                            tx_q    <= 1'b1;
                            state_q <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    tx_q    <= 1'b1;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign tx          = tx_q;
    assign in_ready    = !hold_full_q;
    assign busy        = (state_q != ST_IDLE) || hold_full_q;
    assign frames_sent = frames_q;

endmodule

// File: tb/tb_prng_uart_tx.sv
// Bench for prng_uart_tx: three instances (no/even/odd parity), line monitor with a byte scoreboard.
module tb_prng_uart_tx;

    localparam int unsigned CLK_HZ = 10_000_000;
    localparam int unsigned BAUD   = 1_000_000;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  dat [3];
    logic        vld [3];
    logic        rdy [3];
    logic        txl [3];
    logic        bsy [3];
    logic [15:0] fs  [3];

    int cyc = 0;
    int total = 0;
    int bad = 0;
    int acc_cyc;
    int mon_gap [3];
    logic [9:0] exp_q [$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    prng_uart_tx #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .PARITY(0)) u0 (
        .clk(clk), .rst(rst), .in_data(dat[0]), .in_valid(vld[0]), .in_ready(rdy[0]),
        .tx(txl[0]), .busy(bsy[0]), .frames_sent(fs[0]));
    prng_uart_tx #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .PARITY(1)) u1 (
        .clk(clk), .rst(rst), .in_data(dat[1]), .in_valid(vld[1]), .in_ready(rdy[1]),
        .tx(txl[1]), .busy(bsy[1]), .frames_sent(fs[1]));
    prng_uart_tx #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .PARITY(2)) u2 (
        .clk(clk), .rst(rst), .in_data(dat[2]), .in_valid(vld[2]), .in_ready(rdy[2]),
        .tx(txl[2]), .busy(bsy[2]), .frames_sent(fs[2]));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic wait_cyc(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    // Drive a byte, holding valid until accepted; push the expected byte at the accepting edge
    task automatic send(input int k, input logic [7:0] b);
        int n = 0;
        @(negedge clk);
        dat[k] = b;
        vld[k] = 1'b1;
        while (rdy[k] !== 1'b1 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 3000) begin
            chk("send_timeout", 1, 0);
            vld[k] = 1'b0;
            return;
        end
        @(posedge clk);
        exp_q.push_back({2'(k), b});
        #1;
        acc_cyc = cyc;
        vld[k] = 1'b0;
    endtask

    task automatic wait_frames(input int k, input logic [15:0] target, input int budget);
        int n = 0;
        while (fs[k] !== target && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (n >= budget) chk("frames_timeout", fs[k], target);
    endtask

    // Line monitor: samples mid-bit, checks framing, parity and the byte against the scoreboard
    task automatic mon(input int k);
        bit         inframe = 0;
        int         pos = 0;
        int         nb;
        int         bi;
        int         last_end = -1000;
        logic [9:0] e;
        logic [7:0] eb = '0;
        logic       pexp;
        nb = (k == 0) ? 9 : 10;
        forever begin
            @(negedge clk);
            if (rst) begin
                inframe = 0;
                continue;
            end
            if (!inframe) begin
                if (txl[k] === 1'b0) begin
                    inframe = 1;
                    pos = 0;
                    mon_gap[k] = cyc - last_end;
                end
            end else begin
                pos++;
            end
            if (inframe && (pos % 10) == 4) begin
                bi = pos / 10;
                if (bi == 0) begin
                    chk($sformatf("m%0d_start", k), txl[k], 0);
                    if (exp_q.size() == 0) begin
                        chk($sformatf("m%0d_unexpected_frame", k), 1, 0);
                        eb = '0;
                    end else begin
                        e = exp_q.pop_front();
                        chk($sformatf("m%0d_inst", k), e[9:8], k);
                        eb = e[7:0];
                    end
                end else if (bi <= 8) begin
                    chk($sformatf("m%0d_data%0d_of_%02h", k, bi - 1, eb), txl[k], eb[bi-1]);
                end else if (bi == nb) begin
                    chk($sformatf("m%0d_stop", k), txl[k], 1);
                end else begin
                    pexp = ^eb;
                    if (k == 2) pexp = ~pexp;
                    chk($sformatf("m%0d_parity_of_%02h", k, eb), txl[k], pexp);
                end
            end
            if (inframe && pos == 10 * (nb + 1) - 1) begin
                inframe = 0;
                last_end = cyc + 1;
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit, got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int a;
        int a0;
        int n;

        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            dat[k] = '0;
            vld[k] = 1'b0;
            mon_gap[k] = -1;
        end
        fork
            mon(0);
            mon(1);
            mon(2);
        join_none
        repeat (3) @(posedge clk);
        #1;
        chk("rst_tx", txl[0], 1);
        chk("rst_busy", bsy[0], 0);
        chk("rst_ready", rdy[0], 1);
        chk("rst_frames", fs[0], 16'h0000);
        chk("rst_tx_u1", txl[1], 1);
        @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        // 1: single 0xA5 frame, latency and completion timing
        send(0, 8'hA5);
        a = acc_cyc;
        chk("t1_ready_after_accept", rdy[0], 0);
        chk("t1_busy_after_accept", bsy[0], 1);
        chk("t1_tx_at_accept", txl[0], 1);
        wait_cyc(a + 1);
        chk("t1_tx_falls", txl[0], 0);
        wait_cyc(a + 100);
        chk("t1_frames_before_end", fs[0], 0);
        chk("t1_busy_before_end", bsy[0], 1);
        wait_cyc(a + 101);
        chk("t1_frames_end", fs[0], 1);
        chk("t1_busy_end", bsy[0], 0);
        chk("t1_tx_idle", txl[0], 1);
        repeat (10) @(negedge clk);

        // 2: back-to-back 0x00, 0xFF with no idle gap
        send(0, 8'h00);
        a0 = acc_cyc;
        send(0, 8'hFF);
        chk("t2_ready_low", rdy[0], 0);
        n = 0;
        while (rdy[0] !== 1'b1 && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("t2_ready_rise_cycle", cyc, a0 + 101);
        chk("t2_next_start_bit", txl[0], 0);
        wait_frames(0, 16'd3, 300);
        chk("t2_end_cycle", cyc, a0 + 201);
        chk("t2_gap", mon_gap[0], 0);
        repeat (10) @(negedge clk);

        // 3: backpressure with valid held while ready toggles
        send(0, 8'h11);
        send(0, 8'h22);
        send(0, 8'h33);
        wait_frames(0, 16'd6, 1000);
        repeat (50) @(negedge clk);
        chk("t3_frames", fs[0], 6);
        chk("t3_sb_drained", exp_q.size(), 0);
        chk("t3_busy", bsy[0], 0);

        // 4: even and odd parity on 0x07
        send(1, 8'h07);
        a = acc_cyc;
        wait_cyc(a + 95);
        chk("t4_even_parity_bit", txl[1], 1);
        wait_cyc(a + 110);
        chk("t4_even_frames_before", fs[1], 0);
        wait_cyc(a + 111);
        chk("t4_even_frames_after", fs[1], 1);
        send(2, 8'h07);
        a = acc_cyc;
        wait_cyc(a + 95);
        chk("t4_odd_parity_bit", txl[2], 0);
        wait_cyc(a + 110);
        chk("t4_odd_frames_before", fs[2], 0);
        wait_cyc(a + 111);
        chk("t4_odd_frames_after", fs[2], 1);
        repeat (10) @(negedge clk);

        // 5: reset mid-frame with a byte buffered
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("t5_frames_cleared", fs[0], 0);
        send(0, 8'hFF);
        a = acc_cyc;
        send(0, 8'h3C);
        chk("t5_buffered", rdy[0], 0);
        wait_cyc(a + 44);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("t5_tx", txl[0], 1);
        chk("t5_ready", rdy[0], 1);
        chk("t5_busy", bsy[0], 0);
        chk("t5_frames", fs[0], 0);
        exp_q.delete();
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("t5_still_idle", bsy[0], 0);
        send(0, 8'h3C);
        wait_frames(0, 16'd1, 300);
        chk("t5_resend_frames", fs[0], 1);
        repeat (10) @(negedge clk);

        // 6: frame counter wrap
        @(negedge clk);
        force u0.frames_q = 16'hFFFF;
        @(posedge clk);
        @(negedge clk);
        release u0.frames_q;
        @(negedge clk);
        chk("t6_preload", fs[0], 16'hFFFF);
        send(0, 8'h5A);
        wait_frames(0, 16'h0000, 300);
        chk("t6_wrap", fs[0], 16'h0000);
        repeat (10) @(negedge clk);

        chk("sb_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
